// File: rtl/spi_slave_core.sv
// SPI slave oversampled in the clk domain; all four CPOL/CPHA modes, framed RX.
// Define SPI_SLAVE_MISO_EN to build the MISO/transmit path; otherwise receive-only.
module spi_slave_core #(
  parameter int unsigned WORD_W      = 8,
  parameter int unsigned FRAME_WORDS = 4,
  parameter bit          CPOL        = 1'b1,
  parameter bit          CPHA        = 1'b1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             sclk,
  input  logic                             ss,
  input  logic                             mosi,
  output logic                             miso,
  output logic                             miso_oe,
  input  logic [WORD_W-1:0]                tx_data,
  input  logic                             tx_valid,
  output logic                             tx_ready,
  output logic [WORD_W-1:0]                rx_data,
  output logic                             rx_valid,
  output logic [$clog2(WORD_W)-1:0]        bit_count,
  output logic [$clog2(FRAME_WORDS+1)-1:0] word_count,
  output logic                             frame_done,
  output logic                             tx_underrun
);
  localparam int unsigned BitW  = $clog2(WORD_W);
  localparam int unsigned WordW = $clog2(FRAME_WORDS + 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(WORD_W - 1);
  localparam logic [WordW-1:0] WordLast = WordW'(FRAME_WORDS - 1);

  typedef enum logic [1:0] {StWaitIdle, StIdle, StActive} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, ss_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, ss_prev_q;
  logic                   sclk_s, ss_s, mosi_s;
  logic                   sample_edge, shift_edge, ss_fall;

  // Synchronisers are left unreset so edge history stays valid across a reset.
  always_ff @(posedge clk) begin
    sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss};
    mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    sclk_prev_q <= sclk_s;
    ss_prev_q   <= ss_s;
  end

  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s        = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
  assign sample_edge = (CPOL == CPHA) ? (sclk_s & ~sclk_prev_q) : (~sclk_s & sclk_prev_q);
  assign shift_edge  = (CPOL == CPHA) ? (~sclk_s & sclk_prev_q) : (sclk_s & ~sclk_prev_q);
  assign ss_fall     = ss_prev_q & ~ss_s;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] rx_shift_q, rx_shift_d, rx_data_q, rx_data_d, rx_word;
  logic              rx_valid_q, rx_valid_d, frame_done_q, frame_done_d;
  logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WordW-1:0]  word_cnt_q, word_cnt_d;
  logic              load, load_mid;

  assign rx_word = {rx_shift_q[WORD_W-2:0], mosi_s};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StWaitIdle;
      rx_shift_q   <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      bit_cnt_q    <= '0;
      word_cnt_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_shift_q   <= rx_shift_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      bit_cnt_q    <= bit_cnt_d;
      word_cnt_q   <= word_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    rx_shift_d   = rx_shift_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    bit_cnt_d    = bit_cnt_q;
    word_cnt_d   = word_cnt_q;
    frame_done_d = 1'b0;
    load         = 1'b0;
    load_mid     = 1'b0;
    unique case (state_q)
      StWaitIdle: if (ss_s) state_d = StIdle;
      StIdle: begin
        bit_cnt_d  = '0;
        word_cnt_d = '0;
        if (ss_fall) begin
          load    = 1'b1;
          state_d = StActive;
        end
      end
      StActive: begin
        if (ss_s) begin
          // Partial word is dropped; counters restart with the next frame.
          state_d    = StIdle;
          bit_cnt_d  = '0;
          word_cnt_d = '0;
        end else if (sample_edge) begin
          rx_shift_d = rx_word;
          if (bit_cnt_q == BitLast) begin
            rx_data_d  = rx_word;
            rx_valid_d = 1'b1;
            bit_cnt_d  = '0;
            load       = 1'b1;
            load_mid   = 1'b1;
            if (word_cnt_q == WordLast) begin
              word_cnt_d   = '0;
              frame_done_d = 1'b1;
            end else begin
              word_cnt_d = word_cnt_q + 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StWaitIdle;
    endcase
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign bit_count  = bit_cnt_q;
  assign word_count = word_cnt_q;
  assign frame_done = frame_done_q;

`ifdef SPI_SLAVE_MISO_EN
  logic [WORD_W-1:0] tx_buf_q, tx_buf_d, tx_shift_q, tx_shift_d;
  logic              tx_full_q, tx_full_d, tx_hold_q, tx_hold_d;
  logic              miso_q, miso_d, miso_oe_q, miso_oe_d, tx_underrun_q, tx_underrun_d;
  logic              tx_accept;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_buf_q      <= '0;
      tx_shift_q    <= '0;
      tx_full_q     <= 1'b0;
      tx_hold_q     <= 1'b0;
      miso_q        <= 1'b0;
      miso_oe_q     <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      tx_buf_q      <= tx_buf_d;
      tx_shift_q    <= tx_shift_d;
      tx_full_q     <= tx_full_d;
      tx_hold_q     <= tx_hold_d;
      miso_q        <= miso_d;
      miso_oe_q     <= miso_oe_d;
      tx_underrun_q <= tx_underrun_d;
    end
  end

  // tx_hold marks a shift edge that must present the MSB instead of advancing.
  always_comb begin
    tx_accept     = tx_valid & ~tx_full_q;
    tx_buf_d      = tx_accept ? tx_data : tx_buf_q;
    tx_full_d     = tx_full_q | tx_accept;
    tx_shift_d    = tx_shift_q;
    tx_hold_d     = tx_hold_q;
    miso_d        = miso_q;
    tx_underrun_d = 1'b0;
    miso_oe_d     = (state_d == StActive);
    if (load) begin
      tx_full_d     = tx_accept;
      tx_underrun_d = ~tx_full_q;
      tx_shift_d    = tx_full_q ? tx_buf_q : '0;
      tx_hold_d     = CPHA ? 1'b1 : load_mid;
      if (!CPHA) begin
        miso_d = tx_shift_d[WORD_W-1];
      end else if (!load_mid) begin
        miso_d = 1'b0;
      end
    end else if (state_q == StActive && !ss_s && shift_edge) begin
      if (tx_hold_q) begin
        tx_hold_d = 1'b0;
        miso_d    = tx_shift_q[WORD_W-1];
      end else begin
        tx_shift_d = tx_shift_q << 1;
        miso_d     = tx_shift_q[WORD_W-2];
      end
    end
  end

  assign miso        = miso_q;
  assign miso_oe     = miso_oe_q;
  assign tx_ready    = ~tx_full_q;
  assign tx_underrun = tx_underrun_q;
`else
  logic unused_tx;
  assign unused_tx   = ^{tx_data, tx_valid, load, load_mid, shift_edge};
  assign miso        = 1'b0;
  assign miso_oe     = 1'b0;
  assign tx_ready    = 1'b0;
  assign tx_underrun = 1'b0;
`endif

endmodule

// File: doc/spi_slave_core.md
# spi_slave_core

Parametrised SPI slave that runs entirely in the `clk` domain. It oversamples `sclk`, `ss` and `mosi` through synchronisers and supports all four CPOL/CPHA modes, a configurable word width and a configurable frame length. It adds a full-duplex MISO path with a valid/ready transmit handshake. It replaces the fixed mode-3, MOSI-only receiver and feeds the downstream register/memory logic.

## Interface
- `WORD_W`, 8: bits per word, 4..32.
- `FRAME_WORDS`, 4: words per frame; `frame_done` fires on the last one, 1..256.
- `CPOL`, 1: idle level of `sclk`.
- `CPHA`, 1: 0 = sample on leading edge; 1 = sample on trailing edge.
- `SYNC_STAGES`, 2: synchroniser flops on `sclk`/`ss`/`mosi`, 2..3.

Ports:
- `clk` in 1: system clock; must be ≥ 4× `sclk`.
- `rst_n` in 1: synchronous, active-low reset.
- `sclk` in 1: SPI clock, asynchronous.
- `ss` in 1: slave select, active-low, asynchronous.
- `mosi` in 1: master data, MSB first.
- `miso` out 1: slave data, MSB first.
- `miso_oe` out 1: high while `ss` is low; drives the tri-state pad.
- `tx_data` in WORD_W: next word to send.
- `tx_valid` in 1: `tx_data` is valid.
- `tx_ready` out 1: holding buffer empty; a transfer occurs when `tx_valid && tx_ready`.
- `rx_data` out WORD_W: last complete received word; held until the next word completes.
- `rx_valid` out 1: one-cycle pulse when `rx_data` updates.
- `bit_count` out $clog2(WORD_W): bits sampled in the current word.
- `word_count` out $clog2(FRAME_WORDS+1): completed words in the current frame.
- `frame_done` out 1: one-cycle pulse together with `rx_valid` for word FRAME_WORDS-1.
- `tx_underrun` out 1: one-cycle pulse when a word starts with the holding buffer empty.

## Operation
- Reset values: `miso`=0, `miso_oe`=0, `tx_ready`=1, `rx_data`=0, `rx_valid`=0, `bit_count`=0, `word_count`=0, `frame_done`=0, `tx_underrun`=0. The FSM enters WAIT_IDLE.
- Edge roles:
  - Sample edge is rising when CPOL==CPHA, falling otherwise.
  - Shift edge is the opposite edge.
  - Both are detected on the synchronised `sclk`.
- FSM states:
  - WAIT_IDLE: wait for synced `ss`=1, then go to IDLE. This guarantees that a reset during a frame never resumes partway through the frame.
  - IDLE: `miso_oe`=0. On synced `ss` falling: load TX shift register, set `miso_oe`=1, go to ACTIVE.
  - ACTIVE: on sample edge, shift synced `mosi` into the RX shift register LSB and increment `bit_count`.
    - On the sample edge where `bit_count`==WORD_W-1: update `rx_data`, pulse `rx_valid`, set `bit_count`=0 and load the TX shift register for the next word.
    - `word_count` increments and wraps from FRAME_WORDS-1 to 0, pulsing `frame_done`.
    - On synced `ss` rising: go to IDLE.
- TX load:
  - A load takes the holding buffer, clears it and raises `tx_ready`.
  - If the buffer is empty, the shift register loads all-zero and `tx_underrun` pulses.
- MISO drive:
  - CPHA=0: MSB on `miso` at load; later bits advance on each shift edge.
  - CPHA=1: the first shift edge of each word presents the MSB; later shift edges advance.
  - MISO is driven from the shift register MSB.
- Simultaneous handshake and load: a buffer write in the same cycle as a load writes the new word into the now-empty buffer, so `tx_ready`=0 afterwards.
- `ss` deasserted mid-word:
  - The partial word is discarded; no `rx_valid`.
  - `bit_count` and `word_count` clear.
  - The holding buffer keeps its contents.
- `ss` deasserted at a word boundary clears both counters.
- Glitch rule: edges on synced `sclk` while synced `ss`=1 are ignored.

## Timing
- Input latency: SYNC_STAGES `clk` cycles from pin to internal edge detect.
- `rx_valid`/`rx_data`/`frame_done`: registered one `clk` after the internal sample-edge detect, i.e. SYNC_STAGES+1 cycles after the pin edge.
- `miso` update: SYNC_STAGES+1 `clk` after the pin shift edge (or after `ss` falls for CPHA=0). The master's setup margin therefore requires `clk` ≥ 4× `sclk`.
- `tx_ready` rises one `clk` after the load cycle.
- The word for the first load must be accepted ≥ 1 `clk` before the synced `ss` falling edge.
- The word for a subsequent load must be accepted before the sample edge of that word's last bit.

## Configuration
- `SPI_SLAVE_MISO_EN` defined: TX holding buffer, TX shift register and `tx_underrun` logic are built as described.
- `SPI_SLAVE_MISO_EN` undefined (receive-only build):
  - `miso` and `miso_oe` are tied 0.
  - `tx_ready` is tied 0, `tx_underrun` is tied 0 and `tx_data`/`tx_valid` are ignored.
  - RX behaviour is identical to the full build.

## Test plan
- Mode 3, WORD_W=8, FRAME_WORDS=4: master sends 0xA5,0x3C,0xFF,0x01 -> four `rx_valid` pulses with those values, `frame_done` on 0x01, `word_count` wraps to 0.
- Modes 0,1,2 each: master sends 0x96 while the slave has 0x5A queued -> `rx_data`=0x96 and the master captures 0x5A.
- Two words requested with only 0xC3 queued -> master reads 0xC3 then 0x00, `tx_underrun` pulses once at the second word start.
- `ss` raised after 5 bits, then a new frame sends 0x81 -> no `rx_valid` for the partial word, `rx_data`=0x81, `word_count`=1.
- `rst_n` low for 1 `clk` mid-word with `ss` held low, bits continue -> no `rx_valid` until `ss` goes high and low again; all outputs at their reset values meanwhile.
- Build with `SPI_SLAVE_MISO_EN` undefined, mode 3 frame -> RX results identical; `miso`=0, `miso_oe`=0 and `tx_ready`=0 throughout.
